// File: rtl/pipeline_skid_stage.sv
// Valid/ready inter-stage pipeline register, one WIDTH-bit payload per transfer.
// Define PIPE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipeline_skid_stage #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits for ready, and a producer holding
    // valid keeps its payload until the transfer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_count = state_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             ready_q;

    assign in_ready = ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = RESET_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // in_ready is looked ahead from the next count so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != FULL);
        end
    end
`else
    assign in_ready = !out_valid | out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    // in_fire here implies out_fire: the entry is replaced in place.
                    if (in_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    a_single_entry: assert property (@(posedge clk) disable iff (!rst) state_q != FULL);
`endif

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule
